// File: rtl/processing_unit_v3_pkg.sv
// Shared stage encodings for the union-find decoder processing elements.
package processing_unit_v3_pkg;

  localparam int STAGE_WIDTH = 3;

  // PEELING is appended after RESULT_VALID so existing encodings stay put.
  typedef enum logic [STAGE_WIDTH-1:0] {
    STAGE_IDLE                = 3'd0,
    STAGE_MEASUREMENT_LOADING = 3'd1,
    STAGE_GROW                = 3'd2,
    STAGE_MERGE               = 3'd3,
    STAGE_RESULT_VALID        = 3'd4,
    STAGE_PEELING             = 3'd5
  } stage_e;

endpackage

// File: rtl/processing_unit_v3_min_root_onehot_select.sv
// Combinational minimum finder over valid channels; returns the minimum,
// whether any channel was valid, and a one-hot of the lowest-index winner.
// Feeding equal data turns it into a lowest-index valid picker.
module min_root_onehot_select #(
  parameter int DATA_WIDTH    = 6,
  parameter int CHANNEL_COUNT = 6
) (
  input  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] data_i,
  input  logic [CHANNEL_COUNT-1:0]            valid_i,
  output logic [DATA_WIDTH-1:0]               min_o,
  output logic                                valid_o,
  output logic [CHANNEL_COUNT-1:0]            onehot_o
);

  // Strict less-than keeps the earliest channel on ties.
  always_comb begin
    min_o    = '0;
    valid_o  = 1'b0;
    onehot_o = '0;
    for (int i = 0; i < CHANNEL_COUNT; i++) begin
      if (valid_i[i] && (!valid_o || (data_i[i*DATA_WIDTH +: DATA_WIDTH] < min_o))) begin
        min_o       = data_i[i*DATA_WIDTH +: DATA_WIDTH];
        valid_o     = 1'b1;
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/processing_unit_v3.sv
// Union-find decoder processing element: load, grow, merge and peel for
// one syndrome ancilla.
module processing_unit_v3
  import processing_unit_v3_pkg::*;
#(
  parameter int PER_DIM_BIT_WIDTH = 2,
  parameter int NEIGHBOR_COUNT    = 6,
  parameter int ADDRESS           = 0,
  parameter int ANCILLA_TYPE      = 0,
  parameter int INVERT_X          = 0,
  parameter int BUSY_HOLD         = 2,
  parameter int GROW_CNT_WIDTH    = 4,
  localparam int AW               = 3*PER_DIM_BIT_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         measurement,
  input  logic [STAGE_WIDTH-1:0]       global_stage,
  input  logic [NEIGHBOR_COUNT-1:0]    neighbor_fully_grown,
  input  logic [NEIGHBOR_COUNT*AW-1:0] neighbor_root,
  input  logic [NEIGHBOR_COUNT-1:0]    neighbor_parent_vector,
  input  logic [NEIGHBOR_COUNT-1:0]    neighbor_is_boundary,
  input  logic [NEIGHBOR_COUNT-1:0]    parent_odd,
  input  logic [NEIGHBOR_COUNT-1:0]    child_cluster_parity,
  input  logic [NEIGHBOR_COUNT-1:0]    child_touching_boundary,
  output logic                         neighbor_increase,
  output logic [NEIGHBOR_COUNT-1:0]    parent_vector,
  output logic                         cluster_parity,
  output logic                         cluster_touching_boundary,
  output logic                         odd,
  output logic [AW-1:0]                root,
  output logic                         busy,
  output logic [GROW_CNT_WIDTH-1:0]    grow_count,
  output logic [NEIGHBOR_COUNT-1:0]    correction_vector
);

  localparam int            HW    = $clog2(BUSY_HOLD + 1);
  localparam logic [AW-1:0] ADDR  = AW'(ADDRESS);
  localparam logic          INV_M = (ANCILLA_TYPE == 1) && (INVERT_X == 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(BUSY_HOLD - 1);

  stage_e                    stage_q, last_stage_q;
  logic                      m_q, m_d;
  logic [AW-1:0]             root_q, root_d;
  logic [NEIGHBOR_COUNT-1:0] parent_q, parent_d;
  logic                      parity_q, parity_d;
  logic                      tb_q, tb_d;
  logic                      odd_q, odd_d;
  logic                      busy_q, busy_d;
  logic [HW-1:0]             hold_q, hold_d;
  logic [GROW_CNT_WIDTH-1:0] grow_q, grow_d;
  logic [NEIGHBOR_COUNT-1:0] corr_q, corr_d;

  logic [AW-1:0]             min_root;
  logic                      min_valid;
  logic [NEIGHBOR_COUNT-1:0] min_sel;
  logic                      bnd_valid;
  logic [NEIGHBOR_COUNT-1:0] bnd_sel, bnd_pick;
  logic                      unused_bnd_min;

  logic m_in, grow_fire, root_upd, parity_next, tb_next, odd_next, merge_change;

  min_root_onehot_select #(.DATA_WIDTH(AW), .CHANNEL_COUNT(NEIGHBOR_COUNT)) u_min_root (
    .data_i  (neighbor_root),
    .valid_i (neighbor_fully_grown),
    .min_o   (min_root),
    .valid_o (min_valid),
    .onehot_o(min_sel)
  );

  // All-equal data: the selector degenerates to a lowest-index boundary pick.
  min_root_onehot_select #(.DATA_WIDTH(1), .CHANNEL_COUNT(NEIGHBOR_COUNT)) u_bnd_pick (
    .data_i  ({NEIGHBOR_COUNT{1'b0}}),
    .valid_i (neighbor_is_boundary),
    .min_o   (unused_bnd_min),
    .valid_o (bnd_valid),
    .onehot_o(bnd_sel)
  );

  // Merge-stage candidate values and the change detector driving busy.
  always_comb begin
    m_in         = measurement ^ INV_M;
    grow_fire    = odd_q && (stage_q == STAGE_GROW) && (last_stage_q != STAGE_GROW);
    root_upd     = min_valid && (min_root < root_q);
    parity_next  = m_q ^ (^(neighbor_parent_vector & child_cluster_parity));
    tb_next      = (|(neighbor_parent_vector & child_touching_boundary)) | (|neighbor_is_boundary);
    odd_next     = (parent_q != '0) ? |(parent_q & parent_odd) : (parity_next & ~tb_next);
    merge_change = root_upd || (parity_next != parity_q) || (tb_next != tb_q) || (odd_next != odd_q);
    bnd_pick     = bnd_valid ? bnd_sel : '0;
  end

  // Per-stage next-state; everything holds unless its stage touches it.
  always_comb begin
    m_d      = m_q;
    root_d   = root_q;
    parent_d = parent_q;
    parity_d = parity_q;
    tb_d     = tb_q;
    odd_d    = odd_q;
    busy_d   = busy_q;
    hold_d   = hold_q;
    grow_d   = grow_q;
    corr_d   = corr_q;
    case (stage_q)
      STAGE_MEASUREMENT_LOADING: begin
        m_d      = m_in;
        odd_d    = m_in;
        parity_d = m_in;
        tb_d     = 1'b0;
        root_d   = ADDR;
        parent_d = '0;
        grow_d   = '0;
        corr_d   = '0;
        busy_d   = 1'b0;
        hold_d   = '0;
      end
      STAGE_GROW: begin
        if (grow_fire && (grow_q != '1)) grow_d = grow_q + GROW_CNT_WIDTH'(1);
      end
      STAGE_MERGE: begin
        if (root_upd) begin
          root_d   = min_root;
          parent_d = min_sel;
        end
        parity_d = parity_next;
        tb_d     = tb_next;
        odd_d    = odd_next;
        if (merge_change) begin
          busy_d = 1'b1;
          hold_d = '0;
        end else if (hold_q >= HOLD_LAST) begin
          busy_d = 1'b0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      STAGE_PEELING: begin
        if (parent_q != '0)      corr_d = parent_q & {NEIGHBOR_COUNT{parity_q}};
        else if (parity_q && tb_q) corr_d = bnd_pick;
        else                     corr_d = '0;
      end
      default: ;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q      <= STAGE_IDLE;
      last_stage_q <= STAGE_IDLE;
      m_q          <= 1'b0;
      root_q       <= ADDR;
      parent_q     <= '0;
      parity_q     <= 1'b0;
      tb_q         <= 1'b0;
      odd_q        <= 1'b0;
      busy_q       <= 1'b0;
      hold_q       <= '0;
      grow_q       <= '0;
      corr_q       <= '0;
    end else begin
      stage_q      <= stage_e'(global_stage);
      last_stage_q <= stage_q;
      m_q          <= m_d;
      root_q       <= root_d;
      parent_q     <= parent_d;
      parity_q     <= parity_d;
      tb_q         <= tb_d;
      odd_q        <= odd_d;
      busy_q       <= busy_d;
      hold_q       <= hold_d;
      grow_q       <= grow_d;
      corr_q       <= corr_d;
    end
  end

  assign neighbor_increase         = grow_fire;
  assign parent_vector             = parent_q;
  assign cluster_parity            = parity_q;
  assign cluster_touching_boundary = tb_q;
  assign odd                       = odd_q;
  assign root                      = root_q;
  assign busy                      = busy_q;
  assign grow_count                = grow_q;
  assign correction_vector         = corr_q;

endmodule
